// File: rtl/event_fifo_if.sv
// Handshake bundle between event_fifo and its producer/consumer.
// When EVENT_FIFO_OVERFLOW_EN is defined the bundle also carries overflow and drop_count.
interface event_fifo_if #(
   parameter int WIDTH     = 64,
   parameter int COUNTER_W = 13
);
   logic [WIDTH-2:0]     event_in;
   logic                 load_event;
   logic [WIDTH-2:0]     data_out;
   logic                 data_valid;
   logic                 data_ready;
   logic                 fifo_full;
   logic                 fifo_half;
   logic                 fifo_empty;
   logic [COUNTER_W-1:0] fifo_counter;
`ifdef EVENT_FIFO_OVERFLOW_EN
   logic                 overflow;
   logic [15:0]          drop_count;

   modport master (
      output event_in, load_event, data_ready,
      input  data_out, data_valid, fifo_full, fifo_half, fifo_empty, fifo_counter,
      input  overflow, drop_count
   );

   modport slave (
      input  event_in, load_event, data_ready,
      output data_out, data_valid, fifo_full, fifo_half, fifo_empty, fifo_counter,
      output overflow, drop_count
   );
`else
   modport master (
      output event_in, load_event, data_ready,
      input  data_out, data_valid, fifo_full, fifo_half, fifo_empty, fifo_counter
   );

   modport slave (
      input  event_in, load_event, data_ready,
      output data_out, data_valid, fifo_full, fifo_half, fifo_empty, fifo_counter
   );
`endif
endinterface

// File: rtl/event_fifo.sv
// Shared event FIFO with registered first-word-fall-through output and occupancy flags.
// Optional EVENT_FIFO_OVERFLOW_EN adds a sticky overflow flag and a saturating drop counter.
module event_fifo #(
   parameter int WIDTH      = 64,
   parameter int FIFO_DEPTH = 2048,
   parameter int FIFO_BITS  = 11,
   parameter int COUNTER_W  = 13
) (
   input logic         clk,
   input logic         reset,
   event_fifo_if.slave bus
);
   localparam int CNT_W = FIFO_BITS + 1;
   localparam logic [CNT_W-1:0]     DEPTH_C  = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0]     HALF_C   = CNT_W'(FIFO_DEPTH / 2);
   localparam logic [CNT_W-1:0]     CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [FIFO_BITS-1:0] PTR_ONE  = FIFO_BITS'(1);

   logic [WIDTH-2:0]     mem_q [FIFO_DEPTH];
   logic [FIFO_BITS-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_BITS-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [WIDTH-2:0]     data_out_q;
   logic                 valid_q, valid_d;
   logic                 full_q, full_d;
   logic                 half_q, half_d;
   logic                 empty_q, empty_d;

   logic                 push_s;
   logic                 pop_s;
   logic                 fetch_s;
   logic [CNT_W-1:0]     mem_cnt_s;

   // Next-state for pointers, occupancy, output valid and flags.
   always_comb begin
      push_s    = bus.load_event & ~full_q;
      pop_s     = valid_q & bus.data_ready;
      // Events still in the array exclude the one sitting in data_out.
      mem_cnt_s = count_q - CNT_W'(valid_q);
      fetch_s   = (~valid_q | pop_s) & (mem_cnt_s != CNT_ZERO);

      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (fetch_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
         valid_d  = 1'b1;
      end else if (pop_s) begin
         rd_ptr_d = rd_ptr_q;
         valid_d  = 1'b0;
      end else begin
         rd_ptr_d = rd_ptr_q;
         valid_d  = valid_q;
      end

      count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
      full_d  = (count_d == DEPTH_C);
      half_d  = (count_d >= HALF_C);
      empty_d = (count_d == CNT_ZERO);
   end

   // Storage array write port; contents need no reset since occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push_s && !reset) begin
         mem_q[wr_ptr_q] <= bus.event_in;
      end
   end

   // Control state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= {FIFO_BITS{1'b0}};
         rd_ptr_q <= {FIFO_BITS{1'b0}};
         count_q  <= CNT_ZERO;
         valid_q  <= 1'b0;
         full_q   <= 1'b0;
         half_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
         full_q   <= full_d;
         half_q   <= half_d;
         empty_q  <= empty_d;
      end
   end

   // Output register prefetches the head of the array whenever it is free or being popped.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_out_q <= {(WIDTH-1){1'b0}};
      end else if (fetch_s) begin
         data_out_q <= mem_q[rd_ptr_q];
      end else begin
         data_out_q <= data_out_q;
      end
   end

   assign bus.data_out     = data_out_q;
   assign bus.data_valid   = valid_q;
   assign bus.fifo_full    = full_q;
   assign bus.fifo_half    = half_q;
   assign bus.fifo_empty   = empty_q;
   assign bus.fifo_counter = COUNTER_W'(count_q);

`ifdef EVENT_FIFO_OVERFLOW_EN
   logic        overflow_q, overflow_d;
   logic [15:0] drop_cnt_q, drop_cnt_d;
   logic        drop_s;

   // Drop accounting: a drop is any load while the pre-edge full flag is set.
   always_comb begin
      drop_s = bus.load_event & full_q;
      if (drop_s) begin
         overflow_d = 1'b1;
         drop_cnt_d = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;
      end else begin
         overflow_d = overflow_q;
         drop_cnt_d = drop_cnt_q;
      end
   end

   // Overflow state register, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_q <= 1'b0;
         drop_cnt_q <= 16'd0;
      end else begin
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign bus.overflow   = overflow_q;
   assign bus.drop_count = drop_cnt_q;
`endif
endmodule

// File: doc/event_fifo.md
Name: event_fifo

Overview:
- Shared event FIFO downstream of event_router.
- Captures each 63-bit routed channel event when load_event pulses.
- Buffers events for the serial output/packet stage and presents them on a registered first-word-fall-through valid/ready interface.
- Generates fifo_full, fifo_half, fifo_empty and fifo_counter, which feed back to every channel_ctrl for backpressure and FIFO diagnostics.

Parameters:
- WIDTH, 64, packet width; stored event is WIDTH-1 bits.
- FIFO_DEPTH, 2048, capacity in events; power of 2, at least 4.
- FIFO_BITS, 11, log2(FIFO_DEPTH); pointer width.
- COUNTER_W, 13, width of fifo_counter; must be at least FIFO_BITS+1.

Ports:
- clk  in  1  master clock; one clock; all logic on rising edge.
- reset  in  1  reset is synchronous and active-high.
- event_in  in  WIDTH-1  routed channel event (channel_event_routed).
- load_event  in  1  high for one cycle: write event_in.
- data_out  out  WIDTH-1  head-of-FIFO event, registered.
- data_valid  out  1  data_out holds a valid event.
- data_ready  in  1  consumer accepts data_out this cycle.
- fifo_full  out  1  occupancy == FIFO_DEPTH.
- fifo_half  out  1  occupancy >= FIFO_DEPTH/2.
- fifo_empty  out  1  occupancy == 0.
- fifo_counter  out  COUNTER_W  current occupancy, zero-extended.

Behaviour:
- Reset values (sync, sampled on clk rising edge while reset=1):
  - write/read pointers = 0, occupancy = 0
  - data_out = 0, data_valid = 0
  - fifo_empty = 1, fifo_full = 0, fifo_half = 0, fifo_counter = 0
- Reset mid-operation: all stored events discarded. load_event and data_ready are ignored during the reset cycle.
- Occupancy definition: events accepted and not yet popped, including the one held in the data_out register. Total capacity is exactly FIFO_DEPTH.
- Push: at an edge with load_event=1 and fifo_full=0 (registered value from before the edge), event_in is stored and occupancy increments.
- Push when full: at an edge with load_event=1 and fifo_full=1, the event is dropped and nothing changes. This holds even if a pop occurs on the same edge; full is evaluated before the edge.
- Pop: at an edge with data_valid=1 and data_ready=1, the head is consumed and occupancy decrements.
- data_ready while data_valid=0 has no effect.
- Simultaneous push and pop, not full: occupancy unchanged and order preserved.
- Ordering: strict FIFO; events pop in push order.
- Write-to-valid latency: with the FIFO empty, an event pushed at edge k makes data_valid=1 and data_out=event after edge k+1 (2 edges total).
- Back-to-back pops: after a pop at edge k with occupancy >= 2 before the edge, the next event is on data_out with data_valid=1 immediately after edge k. Sustained throughput is 1 event/clk with no bubbles.
- data_out is stable while data_valid=1 and data_ready=0.
- Flags and fifo_counter are registered and reflect occupancy after the same edge.
- Occupancy transitions:
  - 0 -> 1: fifo_empty falls after the push edge, even though data_valid rises one edge later.
  - FIFO_DEPTH-1 -> FIFO_DEPTH: fifo_full rises.
  - FIFO_DEPTH/2-1 -> FIFO_DEPTH/2: fifo_half rises.
- Pointer wrap: modulo FIFO_DEPTH. Full/empty are distinguished by occupancy, not pointer equality.
- Storage: a single-port-write / single-port-read array is sufficient. The read path prefetches into the data_out register.

Optional Feature:
- Macro: EVENT_FIFO_OVERFLOW_EN.
- Defined: adds output overflow (1 bit) and output drop_count (16 bits).
  - overflow is a sticky flag, set on the edge an event is dropped because the FIFO is full.
  - drop_count increments by 1 per dropped event and saturates at 16'hFFFF.
  - Both clear only on reset; reset value 0.
- Undefined: neither port exists, and dropped events leave no trace.

Test Plan:
- Reset, then push A=63'h1 at edge k with data_ready=0:
  - after edge k: fifo_empty=0, fifo_counter=1
  - after edge k+1: data_valid=1, data_out=1, held while data_ready=0
  - pop: fifo_empty=1, data_valid=0.
- Push 1..2048 on consecutive cycles with data_ready=0:
  - fifo_half rises when the count reaches 1024
  - fifo_full rises when it reaches 2048
  - a 2049th push is dropped
  - then pop with data_ready=1 continuously: values 1..2048 in order at 1/clk, no gaps.
- Fill to 2048, then on one edge assert load_event=1 (value 63'hABC) and data_ready=1:
  - pop occurs, push is dropped, fifo_counter=2047
  - 63'hABC never appears at the output.
- Stream with simultaneous push/pop, 5000 events through a FIFO holding 3: the pointers wrap; fifo_counter stays 3; output order matches input exactly.
- Fill 100 events, assert reset for 1 cycle mid-pop: afterwards fifo_empty=1, fifo_counter=0, data_valid=0, data_out=0; next push behaves as from cold reset.
- With EVENT_FIFO_OVERFLOW_EN: fill to full, then push 3 more:
  - overflow=1, drop_count=3
  - pop all: both stay set
  - reset: both return to 0.
